riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Shares the single data/instruction RAM port between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Sits between the core (pc/fetch logic and the load/store path) and riscv_ram.
- Issues at most one RAM transaction at a time and returns each response to its originator after a fixed memory latency.
- Data requests have priority; a starvation guard guarantees fetch progress.

Parameters:
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..4.
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- clk  in  1  clock.
- x_reset  in  1  synchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch address.
- if_flush  in  1  discard any outstanding fetch response (taken branch).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  load data / store acknowledge.
- d_rdata  out  32  load data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_be  out  4  RAM byte enables.
- mem_addr  out  32  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.

Behaviour:
- Clock and reset: single clock clk. Reset x_reset is synchronous, active-low: sampled on the rising edge of clk, active when 0.
- Reset effects:
  - state=ARB_IDLE; latency counter=0; streak=0; flush_pending=0.
  - All outputs 0.
  - Reset mid-transaction drops the outstanding response silently; no rvalid is issued after reset.
- States:
  - ARB_IDLE: nothing outstanding.
  - ARB_BUSY_I: fetch outstanding.
  - ARB_BUSY_D: data outstanding.
- Issue window: can_issue = (state==ARB_IDLE) or (lat_cnt==1). A response returning in a cycle does not block a new grant in that cycle, so back-to-back throughput is 1 transaction/cycle at MEM_LATENCY=1.
- Grant (combinational, only when can_issue):
  - force_i = if_req and streak==MAX_D_STREAK.
  - If force_i: grant fetch.
  - Else if d_req: grant data.
  - Else if if_req: grant fetch.
  - Exactly one of if_gnt/d_gnt is high per cycle, or neither.
- On grant:
  - mem_en=1 combinationally.
  - mem_we = d_we for data, 0 for fetch.
  - mem_be = d_be for data, 4'hF for fetch.
  - mem_addr/mem_wdata driven from the granted requester; mem_wdata=0 for fetch.
  - Next state = BUSY_I or BUSY_D; lat_cnt loads MEM_LATENCY.
- Counting: lat_cnt decrements each cycle while nonzero.
- Response (lat_cnt==1 in BUSY_x): the owner's rvalid=1 for one cycle, with rdata=mem_rdata.
  - Stores also pulse d_rvalid, with d_rdata=0.
  - Next state = IDLE if no new grant.
  - rdata holds its last value when rvalid=0.
- Streak counter:
  - +1 on each data grant while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any fetch grant, or on any cycle with if_req=0.
- Handshake rules:
  - d_req and d_* must stay stable until d_gnt.
  - if_req may drop without a grant (e.g., after a flush).
  - Address is sampled only in the grant cycle.
- Flush:
  - if_flush while in BUSY_I sets flush_pending; the matching response is suppressed (if_rvalid stays 0).
  - flush_pending clears when that response slot passes.
  - if_flush in the same cycle as if_gnt applies to the newly granted fetch.
  - if_flush with no fetch outstanding has no effect.
  - if_flush never affects data transactions.

Optional Feature:
- Macro RISCV_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_stall (32), perf_d_stall (32), perf_grants (32).
  - perf_if_stall increments per cycle with if_req=1 and if_gnt=0.
  - perf_d_stall increments per cycle with d_req=1 and d_gnt=0.
  - perf_grants increments per cycle with mem_en=1.
  - All three wrap modulo 2^32 and are 0 on reset.
- Undefined: these ports and counters are absent. The remaining behaviour is identical.

Decomposition:
- Into riscv_constants package:
  - typedef enum logic [1:0] ARB_STATE {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}.
  - Localparam ARB_FETCH_BE = 4'hF.
- One sub-module: riscv_perf_cnt, a 32-bit enable-driven wrapping counter with synchronous active-low reset. It is instantiated three times, only under RISCV_ARB_PERF_EN.

Test Plan:
- Fetch only, MEM_LATENCY=1; if_req held, addrs 0x0,0x4,0x8 -> if_gnt every cycle; if_rvalid one cycle after each grant with mem_rdata; mem_be=4'hF; mem_we=0.
- Simultaneous if_req and d_req (store to 0x100, d_be=4'b0011) -> d_gnt first; mem_we=1, mem_be=4'b0011; d_rvalid next cycle with d_rdata=0; fetch granted the following issue slot.
- d_req held 6 cycles with if_req held, MAX_D_STREAK=4 -> 4 data grants, then 1 fetch grant, then data resumes; streak returns to 0.
- MEM_LATENCY=3; fetch granted at cycle 0 -> no grant at cycles 1-2 despite requests; if_rvalid at cycle 3, with a new grant in cycle 3.
- Fetch granted; if_flush=1 at cycle 1 (MEM_LATENCY=2) -> no if_rvalid at cycle 2; the next fetch response is delivered normally.
- Reset asserted one cycle after a data grant (MEM_LATENCY=2) -> d_rvalid never asserts; all outputs 0. After release, the state accepts a new request immediately; perf counters (if enabled) read 0.

Source files
------------

// File: rtl/riscv_constants.sv
// Shared constants for the RISC-V memory arbiter: FSM encoding and the
// fixed byte-enable pattern used for instruction fetches.
package riscv_constants;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } ARB_STATE;

    localparam logic [3:0] ARB_FETCH_BE = 4'hF;

endpackage

// File: rtl/riscv_perf_cnt.sv
// 32-bit event counter: counts cycles with en=1, wraps modulo 2^32,
// synchronous active-low reset.
module riscv_perf_cnt (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        en,
    output logic [31:0] count
);

    // Count enabled cycles, free-running wrap.
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// One transaction in flight at a time; data has priority, with a streak
// limit that forces a fetch grant after MAX_D_STREAK data grants in a row.
// Optional macro RISCV_ARB_PERF_EN adds stall/grant performance counters.
module riscv_mem_arbiter
    import riscv_constants::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef RISCV_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_d_stall,
    output logic [31:0] perf_grants
`endif
);

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    ARB_STATE    state;
    logic [2:0]  lat_cnt;
    logic [3:0]  streak;
    logic        flush_pending;
    logic        store_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        can_issue;
    logic        force_i;
    logic        gnt_i;
    logic        gnt_d;
    logic        resp_slot;
    logic        resp_i;
    logic        resp_d;

    // A returning response frees the port in the same cycle.
    assign can_issue = (state == ARB_IDLE) || (lat_cnt == 3'd1);
    assign force_i   = if_req && (streak == STREAK_MAX);

    // Grant selection; everything is held off while reset is asserted.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (x_reset && can_issue) begin
            if (force_i) begin
                gnt_i = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end else if (if_req) begin
                gnt_i = 1'b1;
            end
        end
    end

    assign if_gnt = gnt_i;
    assign d_gnt  = gnt_d;

    // Drive the RAM port from whichever requester won this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (gnt_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (gnt_i) begin
            mem_en    = 1'b1;
            mem_be    = ARB_FETCH_BE;
            mem_addr  = if_addr;
        end
    end

    // Response slot: the last latency cycle of the outstanding transaction.
    // A flush arriving in the slot itself also discards the returning fetch.
    assign resp_slot = x_reset && (lat_cnt == 3'd1);
    assign resp_i    = resp_slot && (state == ARB_BUSY_I);
    assign resp_d    = resp_slot && (state == ARB_BUSY_D);
    assign if_rvalid = resp_i && !flush_pending && !if_flush;
    assign d_rvalid  = resp_d;

    assign if_rdata = !x_reset  ? 32'h0 :
                      if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = !x_reset  ? 32'h0 :
                      d_rvalid  ? (store_q ? 32'h0 : mem_rdata) : d_rdata_q;

    // Transaction FSM and latency countdown.
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            state   <= ARB_IDLE;
            lat_cnt <= 3'd0;
            store_q <= 1'b0;
        end else if (gnt_i || gnt_d) begin
            state   <= gnt_i ? ARB_BUSY_I : ARB_BUSY_D;
            lat_cnt <= LAT_INIT;
            store_q <= gnt_d && d_we;
        end else if (lat_cnt == 3'd1) begin
            state   <= ARB_IDLE;
            lat_cnt <= 3'd0;
        end else if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Consecutive data grants while fetch is waiting.
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            streak <= 4'd0;
        end else if (!if_req || gnt_i) begin
            streak <= 4'd0;
        end else if (gnt_d && (streak != STREAK_MAX)) begin
            streak <= streak + 4'd1;
        end
    end

    // Remember a flush against the fetch currently in flight.
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            flush_pending <= 1'b0;
        end else if (gnt_i) begin
            flush_pending <= if_flush;
        end else if (lat_cnt == 3'd1) begin
            flush_pending <= 1'b0;
        end else if ((state == ARB_BUSY_I) && if_flush) begin
            flush_pending <= 1'b1;
        end
    end

    // Hold the last delivered read data between responses.
    always_ff @(posedge clk) begin
        if (!x_reset) begin
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= store_q ? 32'h0 : mem_rdata;
            end
        end
    end

`ifdef RISCV_ARB_PERF_EN
    riscv_perf_cnt u_perf_if_stall (
        .clk     (clk),
        .x_reset (x_reset),
        .en      (if_req && !gnt_i),
        .count   (perf_if_stall)
    );

    riscv_perf_cnt u_perf_d_stall (
        .clk     (clk),
        .x_reset (x_reset),
        .en      (d_req && !gnt_d),
        .count   (perf_d_stall)
    );

    riscv_perf_cnt u_perf_grants (
        .clk     (clk),
        .x_reset (x_reset),
        .en      (mem_en),
        .count   (perf_grants)
    );
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter. Three instances with MEM_LATENCY
// 1, 2 and 3 share the same stimulus; each section checks one instance.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        x_reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;

  logic        if_gnt_o    [3];
  logic        if_rvalid_o [3];
  logic [31:0] if_rdata_o  [3];
  logic        d_gnt_o     [3];
  logic        d_rvalid_o  [3];
  logic [31:0] d_rdata_o   [3];
  logic        mem_en_o    [3];
  logic        mem_we_o    [3];
  logic [3:0]  mem_be_o    [3];
  logic [31:0] mem_addr_o  [3];
  logic [31:0] mem_wdata_o [3];
`ifdef RISCV_ARB_PERF_EN
  logic [31:0] perf_if_o   [3];
  logic [31:0] perf_d_o    [3];
  logic [31:0] perf_g_o    [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_mem_arbiter #(
      .MEM_LATENCY  (g + 1),
      .MAX_D_STREAK (4)
    ) u_dut (
      .clk       (clk),
      .x_reset   (x_reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt_o[g]),
      .if_rvalid (if_rvalid_o[g]),
      .if_rdata  (if_rdata_o[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_o[g]),
      .d_rvalid  (d_rvalid_o[g]),
      .d_rdata   (d_rdata_o[g]),
      .mem_en    (mem_en_o[g]),
      .mem_we    (mem_we_o[g]),
      .mem_be    (mem_be_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata)
`ifdef RISCV_ARB_PERF_EN
      ,
      .perf_if_stall (perf_if_o[g]),
      .perf_d_stall  (perf_d_o[g]),
      .perf_grants   (perf_g_o[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before negedge.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    if_flush  = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_be      = 4'h0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;
  endtask

  // Two reset cycles; returns at the start of the first released cycle.
  task automatic do_reset();
    idle_inputs();
    x_reset = 1'b0;
    next();
    next();
    x_reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    x_reset = 1'b0;
    next();
    // Reset with live requests: all outputs forced low.
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h10; mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("rst_if_gnt",   if_gnt_o[0] === 1'b0,     if_gnt_o[0],   1'b0);
    chk("rst_d_gnt",    d_gnt_o[0] === 1'b0,      d_gnt_o[0],    1'b0);
    chk("rst_mem_en",   mem_en_o[0] === 1'b0,     mem_en_o[0],   1'b0);
    chk("rst_mem_addr", mem_addr_o[0] === 32'h0,  mem_addr_o[0], 32'h0);
    chk("rst_if_rdata", if_rdata_o[0] === 32'h0,  if_rdata_o[0], 32'h0);
    chk("rst_d_rdata",  d_rdata_o[0] === 32'h0,   d_rdata_o[0],  32'h0);

    // Fetch-only stream, latency 1.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0;
    settle();
    chk("f_gnt0", if_gnt_o[0] === 1'b1,    if_gnt_o[0],    1'b1);
    chk("f_be0",  mem_be_o[0] === 4'hF,    mem_be_o[0],    4'hF);
    chk("f_we0",  mem_we_o[0] === 1'b0,    mem_we_o[0],    1'b0);
    chk("f_rv0",  if_rvalid_o[0] === 1'b0, if_rvalid_o[0], 1'b0);
    next(); if_addr = 32'h4; mem_rdata = 32'hA000_0000;
    settle();
    chk("f_gnt1",  if_gnt_o[0] === 1'b1,           if_gnt_o[0],    1'b1);
    chk("f_addr1", mem_addr_o[0] === 32'h4,        mem_addr_o[0],  32'h4);
    chk("f_rv1",   if_rvalid_o[0] === 1'b1,        if_rvalid_o[0], 1'b1);
    chk("f_rd1",   if_rdata_o[0] === 32'hA000_0000, if_rdata_o[0], 32'hA000_0000);
    next(); if_addr = 32'h8; mem_rdata = 32'hA000_0004;
    settle();
    chk("f_gnt2", if_gnt_o[0] === 1'b1,            if_gnt_o[0],   1'b1);
    chk("f_rd2",  if_rdata_o[0] === 32'hA000_0004, if_rdata_o[0], 32'hA000_0004);
    next(); if_req = 1'b0; mem_rdata = 32'hA000_0008;
    settle();
    chk("f_gnt3", if_gnt_o[0] === 1'b0,            if_gnt_o[0],    1'b0);
    chk("f_rv3",  if_rvalid_o[0] === 1'b1,         if_rvalid_o[0], 1'b1);
    chk("f_rd3",  if_rdata_o[0] === 32'hA000_0008, if_rdata_o[0],  32'hA000_0008);
    next(); mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("f_rv4",   if_rvalid_o[0] === 1'b0,         if_rvalid_o[0], 1'b0);
    chk("f_hold4", if_rdata_o[0] === 32'hA000_0008, if_rdata_o[0],  32'hA000_0008);
    chk("f_en4",   mem_en_o[0] === 1'b0,            mem_en_o[0],    1'b0);
`ifdef RISCV_ARB_PERF_EN
    chk("f_perf_g", perf_g_o[0] === 32'd3, perf_g_o[0], 32'd3);
`endif

    // Simultaneous store and fetch: data first, store ack with zero data.
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    settle();
    chk("s_dgnt",  d_gnt_o[0] === 1'b1,             d_gnt_o[0],     1'b1);
    chk("s_ignt",  if_gnt_o[0] === 1'b0,            if_gnt_o[0],    1'b0);
    chk("s_we",    mem_we_o[0] === 1'b1,            mem_we_o[0],    1'b1);
    chk("s_be",    mem_be_o[0] === 4'b0011,         mem_be_o[0],    4'b0011);
    chk("s_addr",  mem_addr_o[0] === 32'h100,       mem_addr_o[0],  32'h100);
    chk("s_wdata", mem_wdata_o[0] === 32'hDEAD_BEEF, mem_wdata_o[0], 32'hDEAD_BEEF);
    next(); d_req = 1'b0; d_we = 1'b0; mem_rdata = 32'h1234_5678;
    settle();
    chk("s_drv",    d_rvalid_o[0] === 1'b1,   d_rvalid_o[0],  1'b1);
    chk("s_drd",    d_rdata_o[0] === 32'h0,   d_rdata_o[0],   32'h0);
    chk("s_ignt1",  if_gnt_o[0] === 1'b1,     if_gnt_o[0],    1'b1);
    chk("s_iaddr1", mem_addr_o[0] === 32'h20, mem_addr_o[0],  32'h20);
    chk("s_iwd1",   mem_wdata_o[0] === 32'h0, mem_wdata_o[0], 32'h0);
    next(); if_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    settle();
    chk("s_irv2", if_rvalid_o[0] === 1'b1,         if_rvalid_o[0], 1'b1);
    chk("s_ird2", if_rdata_o[0] === 32'hCAFE_0001, if_rdata_o[0],  32'hCAFE_0001);
    chk("s_drv2", d_rvalid_o[0] === 1'b0,          d_rvalid_o[0],  1'b0);

    // Streak guard: 4 data grants, forced fetch, count restarts from zero.
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
    settle();
    chk("k_d0", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); mem_rdata = 32'h1111_2222;
    settle();
    chk("k_d1",   d_gnt_o[0] === 1'b1,            d_gnt_o[0],    1'b1);
    chk("k_lrv1", d_rvalid_o[0] === 1'b1,         d_rvalid_o[0], 1'b1);
    chk("k_lrd1", d_rdata_o[0] === 32'h1111_2222, d_rdata_o[0],  32'h1111_2222);
    next(); settle();
    chk("k_d2", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); settle();
    chk("k_d3", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); settle();
    chk("k_force_i", if_gnt_o[0] === 1'b1,     if_gnt_o[0],   1'b1);
    chk("k_force_d", d_gnt_o[0] === 1'b0,      d_gnt_o[0],    1'b0);
    chk("k_force_a", mem_addr_o[0] === 32'h40, mem_addr_o[0], 32'h40);
    next(); mem_rdata = 32'h3333_4444;
    settle();
    chk("k_d5",   d_gnt_o[0] === 1'b1,             d_gnt_o[0],     1'b1);
    chk("k_irv5", if_rvalid_o[0] === 1'b1,         if_rvalid_o[0], 1'b1);
    chk("k_ird5", if_rdata_o[0] === 32'h3333_4444, if_rdata_o[0],  32'h3333_4444);
    next(); settle();
    chk("k_d6", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); settle();
    chk("k_d7", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); settle();
    chk("k_d8", d_gnt_o[0] === 1'b1, d_gnt_o[0], 1'b1);
    next(); settle();
    chk("k_force2", if_gnt_o[0] === 1'b1, if_gnt_o[0], 1'b1);

    // Latency 3: port blocked for two cycles, response and new grant together.
    do_reset();
    if_req = 1'b1; if_addr = 32'h80;
    settle();
    chk("l3_gnt0", if_gnt_o[2] === 1'b1, if_gnt_o[2], 1'b1);
    next(); if_addr = 32'h84; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
    settle();
    chk("l3_en1", mem_en_o[2] === 1'b0,    mem_en_o[2],    1'b0);
    chk("l3_rv1", if_rvalid_o[2] === 1'b0, if_rvalid_o[2], 1'b0);
    next(); settle();
    chk("l3_en2", mem_en_o[2] === 1'b0, mem_en_o[2], 1'b0);
    next(); mem_rdata = 32'h55AA_55AA;
    settle();
    chk("l3_rv3",   if_rvalid_o[2] === 1'b1,         if_rvalid_o[2], 1'b1);
    chk("l3_rd3",   if_rdata_o[2] === 32'h55AA_55AA, if_rdata_o[2],  32'h55AA_55AA);
    chk("l3_dgnt3", d_gnt_o[2] === 1'b1,             d_gnt_o[2],     1'b1);
    chk("l3_addr3", mem_addr_o[2] === 32'h300,       mem_addr_o[2],  32'h300);

    // Latency 2: flush suppresses the outstanding fetch only.
    do_reset();
    if_req = 1'b1; if_addr = 32'hC0;
    settle();
    chk("fl_gnt0", if_gnt_o[1] === 1'b1, if_gnt_o[1], 1'b1);
    next(); if_req = 1'b0; if_flush = 1'b1;
    settle();
    chk("fl_rv1", if_rvalid_o[1] === 1'b0, if_rvalid_o[1], 1'b0);
    next(); if_flush = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("fl_rv2", if_rvalid_o[1] === 1'b0, if_rvalid_o[1], 1'b0);
    chk("fl_rd2", if_rdata_o[1] === 32'h0, if_rdata_o[1],  32'h0);
    next(); if_req = 1'b1; if_addr = 32'hC4;
    settle();
    chk("fl_gnt3", if_gnt_o[1] === 1'b1, if_gnt_o[1], 1'b1);
    next(); if_req = 1'b0;
    settle();
    chk("fl_rv4", if_rvalid_o[1] === 1'b0, if_rvalid_o[1], 1'b0);
    next(); mem_rdata = 32'h600D_F00D;
    settle();
    chk("fl_rv5", if_rvalid_o[1] === 1'b1,         if_rvalid_o[1], 1'b1);
    chk("fl_rd5", if_rdata_o[1] === 32'h600D_F00D, if_rdata_o[1],  32'h600D_F00D);

    // Latency 2: reset during an outstanding load drops its response.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h400;
    settle();
    chk("r_dgnt0", d_gnt_o[1] === 1'b1, d_gnt_o[1], 1'b1);
    next(); d_req = 1'b0; x_reset = 1'b0;
    settle();
    chk("r_drv1", d_rvalid_o[1] === 1'b0, d_rvalid_o[1], 1'b0);
    chk("r_en1",  mem_en_o[1] === 1'b0,   mem_en_o[1],   1'b0);
    next(); x_reset = 1'b1; mem_rdata = 32'h7777_7777;
    d_req = 1'b1; d_addr = 32'h404;
    settle();
    chk("r_drv2",  d_rvalid_o[1] === 1'b0,    d_rvalid_o[1], 1'b0);
    chk("r_drd2",  d_rdata_o[1] === 32'h0,    d_rdata_o[1],  32'h0);
    chk("r_dgnt2", d_gnt_o[1] === 1'b1,       d_gnt_o[1],    1'b1);
    chk("r_addr2", mem_addr_o[1] === 32'h404, mem_addr_o[1], 32'h404);
`ifdef RISCV_ARB_PERF_EN
    chk("r_perf_g", perf_g_o[1] === 32'd0,  perf_g_o[1],  32'd0);
    chk("r_perf_d", perf_d_o[1] === 32'd0,  perf_d_o[1],  32'd0);
    chk("r_perf_i", perf_if_o[1] === 32'd0, perf_if_o[1], 32'd0);
`endif
    next(); d_req = 1'b0;
    settle();
    chk("r_drv3", d_rvalid_o[1] === 1'b0, d_rvalid_o[1], 1'b0);
    next(); mem_rdata = 32'h0000_0088;
    settle();
    chk("r_drv4", d_rvalid_o[1] === 1'b1,         d_rvalid_o[1], 1'b1);
    chk("r_drd4", d_rdata_o[1] === 32'h0000_0088, d_rdata_o[1],  32'h0000_0088);

    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
